// File: rtl/mcu51_pkg.sv
// Constants shared by the 8051 fetch stage and the instruction decoder.
package mcu51_pkg;

   localparam int ADDR_W = 16;
   localparam int CODE_W = 8;
   localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO holding {code address, code byte} entries.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DW-1:0]            head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DW-1:0]    mem_q [DEPTH];
   logic [DW-1:0]    mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy; flush overrides push and pop.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = {PTR_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Queue state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DW{1'b0}};
         end
         rd_ptr_q <= {PTR_W{1'b0}};
         wr_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .count (count_q)
   );

endmodule

// File: rtl/fetch_queue_chk.sv
// Protocol checks for the prefetch queue; carries no functional logic.
module fetch_queue_chk #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [$clog2(DEPTH):0]   count
);

   // The issue rule must never let a return land on a full queue.
   assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (count < ($clog2(DEPTH) + 1)'(DEPTH)));

endmodule

// File: rtl/ins_fetch.sv
// 8051 instruction fetch: fetch PC, one-byte-per-cycle program memory reads,
// prefetch queue and valid/ready presentation to the decoder.
module ins_fetch
   import mcu51_pkg::CODE_W;
#(
   parameter int                QUEUE_DEPTH  = 4,
   parameter int                ADDR_W       = mcu51_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = mcu51_pkg::RESET_VECTOR
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                rom_rd_en,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [CODE_W-1:0]   rom_data,
   output logic                ins_valid,
   output logic [CODE_W-1:0]   instruction,
   output logic [ADDR_W-1:0]   ins_pc,
   input  logic                ins_ready,
   input  logic                pc_load,
   input  logic [ADDR_W-1:0]   pc_load_addr
);

   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
   localparam int ENT_W = ADDR_W + CODE_W;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] rd_pc_q, rd_pc_d;
   logic              inflight_q, inflight_d;
   logic              run_q, run_d;
   logic [CNT_W-1:0]  count_s;
   logic [ENT_W-1:0]  head_s;
   logic [CNT_W:0]    occ_s;
   logic              pop_s, push_s, issue_s;

   assign ins_valid             = (count_s != {CNT_W{1'b0}});
   assign {ins_pc, instruction} = head_s;
   assign pop_s                 = ins_valid && ins_ready;
   // A return landing in the redirect cycle belongs to the old stream and is dropped.
   assign push_s                = inflight_q && !pc_load;

   // Issue decision counts queued bytes plus the outstanding read, minus this cycle's pop.
   always_comb begin
      occ_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop_s};
      issue_s = run_q && !pc_load && (occ_s < (CNT_W + 1)'(QUEUE_DEPTH));
      if (issue_s) begin
         rom_rd_en = 1'b1;
         rom_addr  = fetch_pc_q;
      end else begin
         rom_rd_en = 1'b0;
         rom_addr  = {ADDR_W{1'b0}};
      end
   end

   // Next fetch PC, outstanding-read tracking and the post-reset start flag.
   always_comb begin
      run_d      = 1'b1;
      inflight_d = issue_s;
      rd_pc_d    = rd_pc_q;
      fetch_pc_d = fetch_pc_q;
      if (pc_load) begin
         fetch_pc_d = pc_load_addr;
      end else if (issue_s) begin
         fetch_pc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         fetch_pc_d = fetch_pc_q;
      end
      if (issue_s) begin
         rd_pc_d = fetch_pc_q;
      end else begin
         rd_pc_d = rd_pc_q;
      end
   end

   // Fetch control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_VECTOR;
         rd_pc_q    <= {ADDR_W{1'b0}};
         inflight_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_pc_q    <= rd_pc_d;
         inflight_q <= inflight_d;
         run_q      <= run_d;
      end
   end

   fetch_queue #(.DEPTH(QUEUE_DEPTH), .DW(ENT_W)) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data ({rd_pc_q, rom_data}),
      .pop       (pop_s),
      .flush     (pc_load),
      .count     (count_s),
      .head      (head_s)
   );

endmodule
